// File: rtl/lpf_band_controller.sv
// Dry/wet crossfade sequencer for the averaging LPF: fade out, flush, refill, fade in; data_o lags inputs/gain by 1 clk.
// Requests are taken only in IDLE (req_ready_o); anything offered while busy is dropped, not queued.
module lpf_band_controller #(
   parameter  int DWIDTH         = 16,
   parameter  int MAX_LOG2_DEPTH = 5,
   parameter  int RAMP_LOG2      = 4,
   localparam int BW             = $clog2(MAX_LOG2_DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              srst_n_i,
   input  logic              sample_tick_i,
   input  logic [BW-1:0]     band_req_i,
   input  logic              bypass_req_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [DWIDTH-1:0] dry_data_i,
   input  logic [DWIDTH-1:0] wet_data_i,
   output logic [BW-1:0]     band_o,
   output logic              flush_o,
   output logic              busy_o,
   output logic [DWIDTH-1:0] data_o
);

   localparam int GW = RAMP_LOG2 + 1;
   localparam int CW = MAX_LOG2_DEPTH + 1;
   localparam int MW = DWIDTH + RAMP_LOG2 + 1;
   localparam logic [GW-1:0] G_MAX = GW'(1 << RAMP_LOG2);
   localparam logic [BW-1:0] BAND_MAX = BW'(MAX_LOG2_DEPTH);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_FADE_OUT = 3'd1;
   localparam logic [2:0] S_FLUSH    = 3'd2;
   localparam logic [2:0] S_REFILL   = 3'd3;
   localparam logic [2:0] S_FADE_IN  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [GW-1:0]     g_q, g_d;
   logic [BW-1:0]     band_q, band_d;
   logic [BW-1:0]     pend_band_q, pend_band_d;
   logic              pend_byp_q, pend_byp_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DWIDTH-1:0] data_q, data_d;

   logic [BW-1:0]     req_band;
   logic signed [MW-1:0] wet_x, dry_x, g_x, gi_x, mix;
   logic              mix_unused;

   assign req_band = (band_req_i > BAND_MAX) ? BAND_MAX : band_req_i;

   always_comb begin
      state_d     = state_q;
      g_d         = g_q;
      band_d      = band_q;
      pend_band_d = pend_band_q;
      pend_byp_d  = pend_byp_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            // Bypass is simply "parked at zero gain"; a matching request is a no-op.
            if (req_valid_i && !(req_band == band_q && bypass_req_i == (g_q == '0))) begin
               pend_band_d = req_band;
               pend_byp_d  = bypass_req_i;
               state_d     = (g_q != '0) ? S_FADE_OUT : S_FLUSH;
            end
         end
         S_FADE_OUT: begin
            if (sample_tick_i) begin
               g_d = g_q - 1'b1;
               if (g_q == GW'(1)) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (pend_byp_q) begin
               g_d     = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d   = CW'(1) << pend_band_q;
               state_d = S_REFILL;
            end
         end
         S_REFILL: begin
            if (sample_tick_i) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) state_d = S_FADE_IN;
            end
         end
         S_FADE_IN: begin
            if (sample_tick_i) begin
               g_d = g_q + 1'b1;
               if (g_q == G_MAX - 1'b1) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // New depth is presented together with the flush pulse so the filter clears at the new size.
      if (state_d == S_FLUSH && state_q != S_FLUSH) band_d = pend_band_d;
   end

   always_comb begin
      wet_x  = {{(MW-DWIDTH){wet_data_i[DWIDTH-1]}}, wet_data_i};
      dry_x  = {{(MW-DWIDTH){dry_data_i[DWIDTH-1]}}, dry_data_i};
      g_x    = {{(MW-GW){1'b0}}, g_q};
      gi_x   = {{(MW-GW){1'b0}}, G_MAX - g_q};
      mix    = wet_x * g_x + dry_x * gi_x;
      data_d = mix[RAMP_LOG2 +: DWIDTH];
   end

   assign mix_unused = ^{mix[MW-1], mix[RAMP_LOG2-1:0]};

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         state_q     <= S_IDLE;
         g_q         <= '0;
         band_q      <= '0;
         pend_band_q <= '0;
         pend_byp_q  <= 1'b0;
         cnt_q       <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         g_q         <= g_d;
         band_q      <= band_d;
         pend_band_q <= pend_band_d;
         pend_byp_q  <= pend_byp_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
      end
   end

   assign req_ready_o = (state_q == S_IDLE);
   assign busy_o      = (state_q != S_IDLE);
   assign flush_o     = (state_q == S_FLUSH);
   assign band_o      = band_q;
   assign data_o      = data_q;

endmodule

// File: tb/tb_lpf_band_controller.sv
// Directed bench for lpf_band_controller: reset, band change, no-op, bypass, clamp/rounding, reset mid-fade.
module tb_lpf_band_controller;

   logic        clk;
   logic        srst_n;
   logic        tick_s;
   logic [2:0]  band_req;
   logic        byp_req;
   logic        req_vld;
   logic        req_rdy;
   logic [15:0] dry;
   logic [15:0] wet;
   logic [2:0]  band;
   logic        flush;
   logic        busy;
   logic [15:0] data;

   int n_checks = 0;
   int n_errors = 0;
   int flush_cnt = 0;
   int flush_base;

   lpf_band_controller #(
      .DWIDTH(16), .MAX_LOG2_DEPTH(5), .RAMP_LOG2(4)
   ) dut (
      .clk_i(clk), .srst_n_i(srst_n), .sample_tick_i(tick_s),
      .band_req_i(band_req), .bypass_req_i(byp_req), .req_valid_i(req_vld),
      .req_ready_o(req_rdy), .dry_data_i(dry), .wet_data_i(wet),
      .band_o(band), .flush_o(flush), .busy_o(busy), .data_o(data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (flush) flush_cnt++;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      tick_s = 1'b1;
      step();
      tick_s = 1'b0;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic request(input logic [2:0] b, input logic byp);
      band_req = b;
      byp_req  = byp;
      req_vld  = 1'b1;
      step();
      req_vld  = 1'b0;
   endtask

   initial begin
      srst_n = 1'b0; tick_s = 1'b0; band_req = '0; byp_req = 1'b0; req_vld = 1'b0;
      dry = 16'sd1000; wet = 16'sd500;
      repeat (3) step();
      check("rst_data", $signed(data), 0);
      check("rst_band", band, 0);
      check("rst_rdy", req_rdy, 1);
      check("rst_busy", busy, 0);
      check("rst_flush", flush, 0);
      srst_n = 1'b1;
      step();
      check("rel_data", $signed(data), 1000);

      // bypass -> band 3: no fade-out, flush, 8 refill ticks, 16 fade-in ticks
      dry = 16'sd0; wet = 16'sd16000; flush_base = flush_cnt;
      request(3'd3, 1'b0);
      check("acc_busy", busy, 1);
      check("acc_rdy", req_rdy, 0);
      check("acc_flush", flush, 1);
      check("acc_band", band, 3);
      tick();
      check("refill_flush", flush, 0);
      run_ticks(8);
      check("refill_data", $signed(data), 0);
      tick(); step();
      check("fade1_data", $signed(data), 1000);
      run_ticks(7); step();
      check("fade8_data", $signed(data), 8000);
      run_ticks(7);
      check("fade15_busy", busy, 1);
      tick();
      check("fadein_rdy", req_rdy, 1);
      step();
      check("wet_full", $signed(data), 16000);
      check("b3_flush_cnt", flush_cnt - flush_base, 1);

      // repeated identical request is a no-op
      flush_base = flush_cnt;
      request(3'd3, 1'b0);
      check("rep_rdy", req_rdy, 1);
      check("rep_busy", busy, 0);
      step();
      check("rep_flush_cnt", flush_cnt - flush_base, 0);

      // band 3 -> band 5 full wet
      request(3'd5, 1'b0);
      run_ticks(16);
      check("b5_fo_flush", flush, 1);
      step();
      run_ticks(48);
      check("b5_rdy", req_rdy, 1);
      check("b5_band", band, 5);
      dry = 16'sd300; wet = -16'sd700; flush_base = flush_cnt;
      step();
      check("b5_wet", $signed(data), -700);

      // band 5 -> bypass with an ignored request mid-fade
      request(3'd5, 1'b1);
      check("byp_busy", busy, 1);
      run_ticks(8); step();
      check("fo8_data", $signed(data), -200);
      request(3'd2, 1'b0);
      check("ign_busy", busy, 1);
      run_ticks(7);
      check("fo15_flush", flush, 0);
      tick();
      check("byp_flush", flush, 1);
      check("byp_band", band, 5);
      step();
      check("byp_rdy", req_rdy, 1);
      step();
      check("byp_data", $signed(data), 300);
      check("byp_flush_cnt", flush_cnt - flush_base, 1);

      // clamp band 7 -> 5 and negative rounding
      request(3'd1, 1'b1);
      step();
      check("b1_band", band, 1);
      check("b1_rdy", req_rdy, 1);
      dry = -16'sd1000; wet = -16'sd2000;
      request(3'd7, 1'b0);
      check("cl_band", band, 5);
      check("cl_flush", flush, 1);
      step();
      run_ticks(31); step();
      check("cl_refill31", $signed(data), -1000);
      check("cl_busy", busy, 1);
      tick();
      run_ticks(4); step();
      check("neg_round", $signed(data), -1250);

      // reset during fade-in at g=9
      run_ticks(5);
      check("mr_busy_pre", busy, 1);
      flush_base = flush_cnt;
      srst_n = 1'b0;
      step();
      check("mr_rdy", req_rdy, 1);
      check("mr_busy", busy, 0);
      check("mr_data", $signed(data), 0);
      check("mr_band", band, 0);
      srst_n = 1'b1;
      step();
      check("mr_rel_data", $signed(data), -1000);
      check("mr_flush_cnt", flush_cnt - flush_base, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
